// File: rtl/mips_load_store_unit.sv
// Load/store unit for the MIPS datapath: one request at a time, sub-word stores as read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mips_load_store_unit #(
  parameter int LOCATIONS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [29:0] LOC_LIMIT = 30'(LOCATIONS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_A_q, mem_A_d;
  logic [31:0] mem_WD_q, mem_WD_d;

  logic        accept;
  logic        out_of_range;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req_ready    = (state_q == S_IDLE) && !RST;
  assign accept       = req_valid && req_ready;
  assign out_of_range = (req_addr[31:2] >= LOC_LIMIT);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane selection uses the latched low address bits; misaligned bits are simply ignored when unchecked.
  assign byte_sel = mem_RD[{addr_lo_q, 3'b000} +: 8];
  assign half_sel = addr_lo_q[1] ? mem_RD[31:16] : mem_RD[15:0];
  assign sext     = !uns_q;

  always_comb begin
    load_ext = mem_RD;
    case (size_q)
      2'b00:   load_ext = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sext & half_sel[15]}}, half_sel};
      default: load_ext = mem_RD;
    endcase
  end

  always_comb begin
    merged = mem_RD;
    if (size_q == 2'b00) begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_lo_d = addr_lo_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_A_d   = mem_A_q;
    mem_WD_d  = mem_WD_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata[15:0];
          rdata_d   = '0;
          if (out_of_range || misaligned) begin
            state_d = S_ERR;
          end else begin
            mem_A_d = {req_addr[31:2], 2'b00};
            if (!req_we) begin
              state_d = S_LOAD;
            end else if (req_size[1]) begin
              mem_WD_d = req_wdata;
              state_d  = S_WRITE;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        mem_WD_d = merged;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_ERR:   state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_A_q   <= '0;
      mem_WD_q  <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_lo_q <= addr_lo_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_A_q   <= mem_A_d;
      mem_WD_q  <= mem_WD_d;
    end
  end

  // Gating with RST drops an in-flight write the moment reset is raised.
  assign mem_WE     = (state_q == S_WRITE) && !RST;
  assign mem_A      = mem_A_q;
  assign mem_WD     = mem_WD_q;
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a 256-word behavioural data memory.
module tb_mips_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mips_load_store_unit #(.LOCATIONS(256)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always @(posedge CLK) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_WE) mem[mem_A[9:2]] <= mem_WD;
  end
  assign mem_RD = mem[mem_A[9:2]];

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge CLK);
    pl_en = 1'b1; pl_idx = idx[7:0]; pl_data = data;
    @(posedge CLK); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request and observes it until its response (bounded to 8 cycles; lat=-1 on timeout).
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int we_cnt, output logic [31:0] we_a, output logic [31:0] we_d);
    lat = -1; rd = '0; er = 1'b0; we_cnt = 0; we_a = '0; we_d = '0;
    @(negedge CLK);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_WE) begin
        we_cnt++; we_a = mem_A; we_d = mem_WD;
      end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge CLK); #1;
    end
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d writes=%0d",
             we, size, uns, addr, wdata, lat, rd, er, we_cnt);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low actual=%b required=0", req_ready); end
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL rst_we_low actual=%b required=0", mem_WE); end
    RST = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid actual=%b required=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err actual=%b required=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata actual=%h required=00000000", resp_rdata); end
    checks++; if (mem_A !== 32'h0) begin errors++; $display("FAIL rst_mem_A actual=%h required=00000000", mem_A); end
    checks++; if (mem_WD !== 32'h0) begin errors++; $display("FAIL rst_mem_WD actual=%h required=00000000", mem_WD); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after actual=%b required=1", req_ready); end
  endtask

  task automatic test_word;
    int lat; int wc; logic [31:0] rd; logic [31:0] wa; logic [31:0] wd; logic er;
    run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hA5A5A5A5, lat, rd, er, wc, wa, wd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_lat actual=%0d required=2", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL sw_we_cycles actual=%0d required=1", wc); end
    checks++; if (wa !== 32'h4) begin errors++; $display("FAIL sw_mem_A actual=%h required=00000004", wa); end
    checks++; if (wd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sw_mem_WD actual=%h required=a5a5a5a5", wd); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp actual=err %b rdata %h required=err 0 rdata 0", er, rd); end
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_lat actual=%0d required=2", lat); end
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL lw_data actual=%h required=a5a5a5a5", rd); end
    checks++; if (wc !== 0 || er !== 1'b0) begin errors++; $display("FAIL lw_side actual=writes %0d err %b required=writes 0 err 0", wc, er); end
  endtask

  task automatic test_subword_store;
    int lat; int wc; logic [31:0] rd; logic [31:0] wa; logic [31:0] wd; logic er;
    preload(2, 32'h5A5A5A5A);
    run_req(1'b1, 2'b00, 1'b0, 32'hA, 32'h000000EE, lat, rd, er, wc, wa, wd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_lat actual=%0d required=3", lat); end
    checks++; if (wc !== 1 || wa !== 32'h8) begin errors++; $display("FAIL sb_write actual=writes %0d addr %h required=writes 1 addr 00000008", wc, wa); end
    checks++; if (wd !== 32'h5AEE5A5A) begin errors++; $display("FAIL sb_merge actual=%h required=5aee5a5a", wd); end
    checks++; if (mem[2] !== 32'h5AEE5A5A) begin errors++; $display("FAIL sb_mem actual=%h required=5aee5a5a", mem[2]); end
    run_req(1'b1, 2'b01, 1'b0, 32'h8, 32'hFFFF1234, lat, rd, er, wc, wa, wd);
    checks++; if (lat !== 3 || wd !== 32'h5AEE1234) begin errors++; $display("FAIL sh_merge actual=lat %0d data %h required=lat 3 data 5aee1234", lat, wd); end
    run_req(1'b1, 2'b00, 1'b0, 32'hB, 32'hFFFFFF77, lat, rd, er, wc, wa, wd);
    checks++; if (mem[2] !== 32'h77EE1234) begin errors++; $display("FAIL sb_lane3 actual=%h required=77ee1234", mem[2]); end
  endtask

  task automatic test_loads;
    int lat; int wc; logic [31:0] rd; logic [31:0] wa; logic [31:0] wd; logic er;
    preload(3, 32'h80FF7F01);
    run_req(1'b0, 2'b00, 1'b0, 32'hC, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL lb_C actual=%h required=00000001", rd); end
    run_req(1'b0, 2'b00, 1'b0, 32'hD, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (rd !== 32'h0000007F || lat !== 2) begin errors++; $display("FAIL lb_D actual=%h lat %0d required=0000007f lat 2", rd, lat); end
    run_req(1'b0, 2'b00, 1'b0, 32'hE, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_E actual=%h required=ffffffff", rd); end
    run_req(1'b0, 2'b00, 1'b1, 32'hE, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL lbu_E actual=%h required=000000ff", rd); end
    run_req(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_E actual=%h required=ffff80ff", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (rd !== 32'h000080FF) begin errors++; $display("FAIL lhu_E actual=%h required=000080ff", rd); end
  endtask

  task automatic test_errors;
    int lat; int wc; logic [31:0] rd; logic [31:0] wa; logic [31:0] wd; logic er;
    run_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, lat, rd, er, wc, wa, wd);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL oor_store actual=lat %0d err %b required=lat 1 err 1", lat, er); end
    checks++; if (wc !== 0 || rd !== 32'h0) begin errors++; $display("FAIL oor_side actual=writes %0d rdata %h required=writes 0 rdata 0", wc, rd); end
    preload(255, 32'h13579BDF);
    run_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, rd, er, wc, wa, wd);
    checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h13579BDF) begin errors++; $display("FAIL last_word actual=lat %0d err %b data %h required=lat 2 err 0 data 13579bdf", lat, er, rd); end
    preload(1, 32'h1234A5A5);
    run_req(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, lat, rd, er, wc, wa, wd);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_misalign actual=lat %0d err %b data %h required=lat 1 err 1 data 0", lat, er, rd); end
`else
    checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFFA5A5) begin errors++; $display("FAIL lh_unaligned actual=lat %0d err %b data %h required=lat 2 err 0 data ffffa5a5", lat, er, rd); end
`endif
    run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, rd, er, wc, wa, wd);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL lw_misalign actual=lat %0d err %b required=lat 1 err 1", lat, er); end
`else
    checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h1234A5A5) begin errors++; $display("FAIL lw_unaligned actual=lat %0d err %b data %h required=lat 2 err 0 data 1234a5a5", lat, er, rd); end
`endif
  endtask

  task automatic test_reset_mid;
    int bad;
    preload(4, 32'h11223344);
    @(negedge CLK);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h99;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    checks++; if (mem_WE !== 1'b1) begin errors++; $display("FAIL rmid_write_cycle actual=%b required=1", mem_WE); end
    RST = 1'b1; #1;
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL rmid_we_gated actual=%b required=0", mem_WE); end
    @(posedge CLK); #1;
    RST = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready actual=%b required=1", req_ready); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || mem_WE) bad++;
      @(posedge CLK); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_no_resp actual=%0d required=0", bad); end
    checks++; if (mem[4] !== 32'h11223344) begin errors++; $display("FAIL rmid_mem actual=%h required=11223344", mem[4]); end
    $display("txn reset during sub-word store write cycle");
  endtask

  task automatic test_back_to_back;
    int acc[2]; int rsp[2]; int na; int nr; int overlap; logic [31:0] rd0;
    acc = '{-1, -1}; rsp = '{-1, -1}; na = 0; nr = 0; overlap = 0; rd0 = '0;
    preload(1, 32'hA5A5A5A5);
    preload(4, 32'h0);
    @(negedge CLK);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (na >= 2) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        if (na < 2) acc[na] = k;
        na++;
      end
      if (resp_valid) begin
        if (nr < 2) rsp[nr] = k;
        if (nr == 0) rd0 = resp_rdata;
        nr++;
        if (req_ready) overlap++;
      end
      if (k == 1) begin
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
      end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    $display("txn back-to-back: accepts at %0d,%0d responses at %0d,%0d", acc[0], acc[1], rsp[0], rsp[1]);
    checks++; if (na !== 2 || nr !== 2) begin errors++; $display("FAIL b2b_counts actual=acc %0d resp %0d required=acc 2 resp 2", na, nr); end
    checks++; if (acc[0] !== 0 || acc[1] !== 3) begin errors++; $display("FAIL b2b_accept actual=%0d,%0d required=0,3", acc[0], acc[1]); end
    checks++; if (rsp[0] !== 2 || rsp[1] !== 5) begin errors++; $display("FAIL b2b_resp actual=%0d,%0d required=2,5", rsp[0], rsp[1]); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap actual=%0d required=0", overlap); end
    checks++; if (rd0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_rdata actual=%h required=a5a5a5a5", rd0); end
    checks++; if (mem[4] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_store actual=%h required=cafef00d", mem[4]); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
